fifo_nibble_packer: RTL and testbench
=====================================

FIFO_NIBBLE_PACKER -- requirements
Module: fifo_nibble_packer

Interface
REQ-001 The block SHALL have parameter data_width, default 4, the FIFO read-data width in bits.
REQ-002 The block SHALL have parameter pack, default 4, the number of FIFO entries packed into one output word.
REQ-003 The block SHALL have port rd_clk  input  1  the single clock.
REQ-004 The block SHALL have port rd_reset  input  1  asynchronous active-high reset.
REQ-005 The block SHALL have port fifo_empty  input  1  the registered empty flag from the async FIFO read side.
REQ-006 The block SHALL have port fifo_data  input  data_width  FIFO read data, valid the cycle after a read.
REQ-007 The block SHALL have port fifo_rd_en  output  1  the FIFO read request.
REQ-008 The block SHALL have port flush  input  1  a single-cycle request to emit a partially filled word.
REQ-009 The block SHALL have port m_data  output  data_width*pack  the packed output word.
REQ-010 The block SHALL have port m_count  output  clog2(pack)+1  the number of valid entries in m_data.
REQ-011 The block SHALL have port m_valid  output  1  asserted while the output word is valid.
REQ-012 The block SHALL have port m_ready  input  1  the downstream accept signal.

Function
REQ-013 fifo_rd_en SHALL be combinational: !fifo_empty && (fill + inflight < pack) && state != S_FLUSH, so no read is ever issued while fifo_empty=1 and the FIFO underflow flag is never set.
REQ-014 inflight SHALL be fifo_rd_en registered; a FIFO read has a fixed latency of 1 cycle.
REQ-015 When inflight=1, fifo_data SHALL be captured into lane[fill] and fill SHALL increment; lane 0 (m_data LSBs) holds the first entry read.
REQ-016 The FSM SHALL have the states S_FILL, S_FULL and S_FLUSH; reset state S_FILL.
REQ-017 S_FILL -> S_FULL SHALL occur when fill reaches pack.
REQ-018 In S_FULL, when (!m_valid || m_ready), the lanes SHALL load m_data, m_count=pack, m_valid=1, fill=0 and the FSM SHALL return to S_FILL.
REQ-019 A flush seen with fill+inflight>0 SHALL be latched sticky and SHALL enter S_FLUSH; a flush with fill+inflight=0 SHALL be ignored.
REQ-020 In S_FLUSH, no new reads SHALL issue; once inflight=0 and (!m_valid || m_ready), the word SHALL be emitted with m_count=fill, unused lanes zero, fill=0, FSM -> S_FILL.
REQ-021 A flush that arrives while in S_FULL SHALL be served by the full word; no empty word SHALL ever be emitted.
REQ-022 m_data and m_count SHALL hold stable while m_valid && !m_ready; m_valid SHALL clear on m_ready unless a new word loads in the same cycle.
REQ-023 With the FIFO never empty and m_ready=1, sustained throughput SHALL be one word per pack+2 cycles.

Reset
REQ-024 On rd_reset=1: fifo_rd_en=0, m_valid=0, m_data=0, m_count=0, fill=0, inflight=0, flush latch=0, FSM=S_FILL, all immediately without a clock edge.
REQ-025 A reset asserted mid-word SHALL discard the partial lanes; the block SHALL NOT emit them after release.
REQ-026 After reset release, the first fifo_rd_en SHALL NOT assert before the first rd_clk edge.

Structure
REQ-027 A shared package fifo_pkg SHALL hold the data_width and pack defaults and the FSM state enum.
REQ-028 The block SHALL be a single module with no sub-modules.

Verification
REQ-029 The bench SHALL read FIFO entries 1,2,3,4 with m_ready=1 and require m_data=16'h4321, m_count=4, and m_valid high for 1 cycle.
REQ-030 The bench SHALL read entries A,B, pulse flush, and require m_data=16'h00BA, m_count=2, with no fifo_rd_en during S_FLUSH.
REQ-031 The bench SHALL hold m_ready=0 across two full words and require the first word stable, fifo_rd_en=0 once the lanes are full, and no data lost after m_ready=1.
REQ-032 The bench SHALL toggle fifo_empty randomly and require fifo_rd_en never high while fifo_empty=1, with the output sequence in order.
REQ-033 The bench SHALL assert rd_reset after 3 entries and require m_valid=0 and fill=0 immediately, and that the next word contains only post-reset entries.
REQ-034 The bench SHALL pulse flush with an empty pipeline and require no output word and the FSM to stay in S_FILL.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO nibble packer.
//   DATA_WIDTH_DEF : default FIFO read-data width in bits
//   PACK_DEF       : default number of FIFO entries packed per output word
//   state_t        : packer FSM state encoding
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int PACK_DEF       = 4;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_nibble_packer.sv
// Packs `pack` consecutive entries read from an async FIFO read port into
// one output word. Lane 0 (m_data LSBs) holds the first entry read. A flush
// request pushes out a partially filled word, with unused lanes zero.
//
// Ports
//   rd_clk       : single clock
//   rd_reset     : asynchronous active-high reset
//   fifo_empty   : registered empty flag from the FIFO read side
//   fifo_data    : FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en   : FIFO read request (combinational)
//   flush        : single-cycle request to emit a partial word
//   m_data       : packed output word
//   m_count      : number of valid entries in m_data
//   m_valid      : output word valid
//   m_ready      : downstream accept
//   o_dbg_state  : current FSM state (debug)
//   o_dbg_fill   : number of lanes currently filled (debug)
//
// Output handshake: a word transfers on every rd_clk edge where
// m_valid && m_ready. While m_valid && !m_ready, m_data and m_count hold
// stable. A new word may load on the same edge the previous one transfers.
module fifo_nibble_packer
  import fifo_pkg::*;
#(
  parameter int  data_width = DATA_WIDTH_DEF,
  parameter int  pack       = PACK_DEF,
  localparam int CW         = $clog2(pack) + 1
) (
  input  logic                       rd_clk,
  input  logic                       rd_reset,
  input  logic                       fifo_empty,
  input  logic [data_width-1:0]      fifo_data,
  output logic                       fifo_rd_en,
  input  logic                       flush,
  output logic [data_width*pack-1:0] m_data,
  output logic [CW-1:0]              m_count,
  output logic                       m_valid,
  input  logic                       m_ready,
  output state_t                     o_dbg_state,
  output logic [CW-1:0]              o_dbg_fill
);

  state_t                                r_state;
  logic [CW-1:0]                         r_fill;
  logic                                  r_inflight;
  logic                                  r_flush_pend;
  logic                                  r_started;
  logic [pack-1:0][data_width-1:0]       r_lanes;

  logic [CW:0]                           w_pending;
  logic                                  w_out_free;
  logic                                  w_flush_ok;
  logic                                  w_last_cap;

  // Lanes already filled plus the one read still in flight.
  assign w_pending  = {1'b0, r_fill} + {{CW{1'b0}}, r_inflight};
  assign w_out_free = !m_valid || m_ready;
  // A flush only matters when there is something to emit.
  assign w_flush_ok = flush && (w_pending != '0);
  // The in-flight entry lands in the last lane on this edge.
  assign w_last_cap = r_inflight && (r_fill == CW'(pack - 1));

  // r_started keeps the read request low from reset release until the
  // first clock edge, even if the FIFO is already non-empty.
  assign fifo_rd_en = r_started && !fifo_empty &&
                      (w_pending < (CW + 1)'(pack)) && (r_state != S_FLUSH);

  assign o_dbg_state = r_state;
  assign o_dbg_fill  = r_fill;

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      r_state      <= S_FILL;
      r_fill       <= '0;
      r_inflight   <= 1'b0;
      r_flush_pend <= 1'b0;
      r_started    <= 1'b0;
      r_lanes      <= '0;
      m_data       <= '0;
      m_count      <= '0;
      m_valid      <= 1'b0;
    end else begin
      r_started  <= 1'b1;
      r_inflight <= fifo_rd_en;

      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end

      // Fixed one-cycle read latency: the entry requested last cycle is on
      // fifo_data now and goes into the next free lane.
      if (r_inflight) begin
        for (int i = 0; i < pack; i++) begin
          if (r_fill == CW'(i)) begin
            r_lanes[i] <= fifo_data;
          end
        end
        r_fill <= r_fill + 1'b1;
      end

      case (r_state)
        S_FILL: begin
          if (w_flush_ok) begin
            r_flush_pend <= 1'b1;
          end
          // A full word takes precedence: it also serves a pending flush.
          if (w_last_cap) begin
            r_state <= S_FULL;
          end else if (w_flush_ok || r_flush_pend) begin
            r_state <= S_FLUSH;
          end
        end

        S_FULL: begin
          if (w_out_free) begin
            m_data       <= r_lanes;
            m_count      <= CW'(pack);
            m_valid      <= 1'b1;
            r_fill       <= '0;
            r_lanes      <= '0;
            r_flush_pend <= 1'b0;
            r_state      <= S_FILL;
          end else if (w_flush_ok) begin
            r_flush_pend <= 1'b1;
          end
        end

        S_FLUSH: begin
          // Wait for the last in-flight entry, then emit what is there.
          if (!r_inflight && w_out_free) begin
            m_data       <= r_lanes;
            m_count      <= r_fill;
            m_valid      <= 1'b1;
            r_fill       <= '0;
            r_lanes      <= '0;
            r_flush_pend <= 1'b0;
            r_state      <= S_FILL;
          end
        end

        default: begin
          r_state <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Directed bench for fifo_nibble_packer (data_width=4, pack=4).
module tb_fifo_nibble_packer;
  import fifo_pkg::*;

  localparam int DW = 4;
  localparam int P  = 4;
  localparam int CW = $clog2(P) + 1;
  localparam int EW = CW + DW * P;

  logic            rd_clk = 1'b0;
  logic            rd_reset = 1'b1;
  logic            fifo_empty = 1'b1;
  logic [DW-1:0]   fifo_data = '0;
  logic            fifo_rd_en;
  logic            flush = 1'b0;
  logic [DW*P-1:0] m_data;
  logic [CW-1:0]   m_count;
  logic            m_valid;
  logic            m_ready = 1'b1;
  state_t          o_dbg_state;
  logic [CW-1:0]   o_dbg_fill;

  fifo_nibble_packer #(.data_width(DW), .pack(P)) dut (
    .rd_clk(rd_clk), .rd_reset(rd_reset), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .m_data(m_data), .m_count(m_count), .m_valid(m_valid),
    .m_ready(m_ready), .o_dbg_state(o_dbg_state), .o_dbg_fill(o_dbg_fill)
  );

  // ---------------- clock / reset ----------------
  always #5 rd_clk = ~rd_clk;

  int cyc = 0;
  always @(posedge rd_clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int viol_empty = 0;
  int viol_flush = 0;
  int underflow = 0;
  int n_acc = 0;
  int acc_t[$];
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] src_q[$];
  logic rand_empty = 1'b0;
  logic gate_empty = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO read-side model: registered empty flag, data one cycle after read.
  always @(posedge rd_clk) begin
    logic rd_hit;
    rd_hit = fifo_rd_en;
    #1;
    if (rd_hit) begin
      if (src_q.size() == 0) underflow++;
      else fifo_data = src_q.pop_front();
    end
    gate_empty = rand_empty ? 1'($urandom_range(0, 1)) : 1'b0;
    fifo_empty = (src_q.size() == 0) || gate_empty;
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge rd_clk) begin
    logic [EW-1:0] e;
    if (!rd_reset) begin
      if (fifo_rd_en && fifo_empty) viol_empty++;
      if (o_dbg_state == S_FLUSH && fifo_rd_en) viol_flush++;
      if (m_valid && m_ready) begin
        n_acc++;
        acc_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("m_count", 32'(m_count), 32'(e[EW-1:DW*P]));
          check("m_data", 32'(m_data), 32'(e[DW*P-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] d);
    src_q.push_back(d);
  endtask

  task automatic expect_word(input logic [CW-1:0] cnt, input logic [DW*P-1:0] d);
    exp_q.push_back({cnt, d});
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_exp_empty(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !m_valid) break;
      tick();
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_fill(input string tag, input logic [CW-1:0] n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (o_dbg_fill == n) break;
      tick();
    end
    check(tag, 32'(o_dbg_fill), 32'(n));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc0;

    // Reset values, FIFO already holding 1,2,3,4.
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    expect_word(3'd4, 16'h4321);
    #1;
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_count", 32'(m_count), 32'd0);
    check("rst_fill", 32'(o_dbg_fill), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'(S_FILL));
    repeat (3) @(negedge rd_clk);
    #2 rd_reset = 1'b0;
    #1 check("rd_en_before_first_edge", 32'(fifo_rd_en), 32'd0);

    // Basic word 4321, m_valid high for one cycle.
    wait_exp_empty("basic_word_timeout", 60);
    check("m_valid_one_cycle", 32'(m_valid), 32'd0);
    wait_drain("basic_drain", 20);

    // Sustained throughput: one word every pack+2 cycles.
    acc_t.delete();
    push(4'hC); push(4'h3); push(4'h5); push(4'hA);
    push(4'hF); push(4'h0); push(4'h7); push(4'hE);
    expect_word(3'd4, 16'hA53C);
    expect_word(3'd4, 16'hE70F);
    wait_drain("thru_drain", 80);
    check("thru_words", 32'(acc_t.size()), 32'd2);
    if (acc_t.size() >= 2) check("thru_period", 32'(acc_t[1] - acc_t[0]), 32'd6);

    // Flush of a partial word, with reads blocked in S_FLUSH.
    m_ready = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    expect_word(3'd4, 16'h4321);
    push(4'hA); push(4'hB);
    repeat (8) tick();
    wait_fill("flush_fill2", 3'd2, 40);
    check("flush_hold_valid", 32'(m_valid), 32'd1);
    push(4'hC); push(4'hD); push(4'hE); push(4'hF);
    pulse_flush();
    check("flush_state", 32'(o_dbg_state), 32'(S_FLUSH));
    repeat (4) tick();
    check("flush_state_hold", 32'(o_dbg_state), 32'(S_FLUSH));
    check("flush_no_rd_en", 32'(fifo_rd_en), 32'd0);
    check("flush_fill_hold", 32'(o_dbg_fill), 32'd2);
    expect_word(3'd2, 16'h00BA);
    expect_word(3'd4, 16'hFEDC);
    m_ready = 1'b1;
    wait_drain("flush_drain", 80);

    // Backpressure across two full words, flush while full.
    m_ready = 1'b0;
    for (int i = 1; i <= 9; i++) push(DW'(i));
    expect_word(3'd4, 16'h4321);
    expect_word(3'd4, 16'h8765);
    repeat (40) tick();
    check("bp_valid", 32'(m_valid), 32'd1);
    check("bp_data", 32'(m_data), 32'h4321);
    check("bp_state_full", 32'(o_dbg_state), 32'(S_FULL));
    check("bp_fill", 32'(o_dbg_fill), 32'd4);
    check("bp_rd_en_low", 32'(fifo_rd_en), 32'd0);
    pulse_flush();
    repeat (5) tick();
    check("bp_data_stable", 32'(m_data), 32'h4321);
    check("bp_count_stable", 32'(m_count), 32'd4);
    m_ready = 1'b1;
    wait_exp_empty("bp_release", 40);
    expect_word(3'd1, 16'h0009);
    wait_fill("bp_tail_fill", 3'd1, 40);
    pulse_flush();
    wait_drain("bp_drain", 40);

    // Randomly toggled empty flag; ordering must hold.
    rand_empty = 1'b1;
    for (int i = 0; i < 12; i++) push(DW'(i));
    expect_word(3'd4, 16'h3210);
    expect_word(3'd4, 16'h7654);
    expect_word(3'd4, 16'hBA98);
    wait_drain("rand_drain", 400);
    rand_empty = 1'b0;
    repeat (3) tick();

    // Reset mid-word discards partial lanes and the held word.
    m_ready = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4);
    push(4'h1); push(4'h2); push(4'h3);
    repeat (30) tick();
    check("rst_pre_valid", 32'(m_valid), 32'd1);
    check("rst_pre_fill", 32'(o_dbg_fill), 32'd3);
    #1 rd_reset = 1'b1;
    #1;
    check("rst_mid_valid", 32'(m_valid), 32'd0);
    check("rst_mid_fill", 32'(o_dbg_fill), 32'd0);
    check("rst_mid_rd_en", 32'(fifo_rd_en), 32'd0);
    repeat (2) tick();
    rd_reset = 1'b0;
    m_ready = 1'b1;
    push(4'h5); push(4'h6); push(4'h7); push(4'h8);
    expect_word(3'd4, 16'h8765);
    wait_drain("rst_post_drain", 60);

    // Flush with nothing in the pipeline is ignored.
    repeat (3) tick();
    check("idle_fill", 32'(o_dbg_fill), 32'd0);
    acc0 = n_acc;
    pulse_flush();
    check("idle_flush_state", 32'(o_dbg_state), 32'(S_FILL));
    repeat (6) tick();
    check("idle_flush_state_later", 32'(o_dbg_state), 32'(S_FILL));
    check("idle_flush_no_word", 32'(n_acc - acc0), 32'd0);
    check("idle_flush_valid", 32'(m_valid), 32'd0);

    // Global invariants.
    check("rd_en_while_empty", 32'(viol_empty), 32'd0);
    check("rd_en_in_flush", 32'(viol_flush), 32'd0);
    check("fifo_underflow", 32'(underflow), 32'd0);
    check("src_all_consumed", 32'(src_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
